// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: architectural constants and the MEM/WB register layout,
// reused by the writeback stage and the hazard unit.
package pipeline_pkg;

  localparam logic [4:0] XZR       = 5'd31;
  localparam int         PIPE_DATA_W = 64;

  typedef struct packed {
    logic                   wb_valid;
    logic                   wb_RegWrite;
    logic                   wb_MemToReg;
    logic [4:0]             wb_Rd;
    logic [PIPE_DATA_W-1:0] wb_ALUResult;
    logic [PIPE_DATA_W-1:0] wb_ReadData;
  } memwb_t;

endpackage

// File: rtl/mux_2to1.sv
// One-bit 2:1 multiplexer primitive: sel=1 picks b, sel=0 picks a.
module mux_2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_64x2to1.sv
// Word-wide 2:1 multiplexer built as a bank of 1-bit mux_2to1 primitives.
module mux_64x2to1 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    mux_2to1 u_mux (
      .a   (a[i]),
      .b   (b[i]),
      .sel (sel),
      .y   (y[i])
    );
  end

endmodule

// File: rtl/writeback_stage.sv
// LEGv8 writeback stage: MEM/WB register, writeback select, register-file write port,
// decode bypass detection and retired-instruction counter.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_valid,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemToReg,
  input  logic [4:0]        MEM_Rd,
  input  logic [DATA_W-1:0] MEM_ALUResult,
  input  logic [DATA_W-1:0] MEM_ReadData,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        ID_Rn,
  input  logic [4:0]        ID_Ab,
  output logic              RegWrite_toReg,
  output logic [4:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              bypassA,
  output logic              bypassB,
  output logic [CNT_W-1:0]  retired
);

  memwb_t           wb_r;
  memwb_t           wb_next_s;
  logic             wb_en_s;
  logic             reg_write_s;
  logic [CNT_W-1:0] retired_r;

  // Reset and flush override the stall enable so a bubble always gets in.
  assign wb_en_s = ~stall | flush | reset;

  // MEM/WB next-state: reset/flush gate the D input to a cleared bubble
  always_comb begin
    wb_next_s = '0;
    if (reset || flush) begin
      wb_next_s = '0;
    end else begin
      wb_next_s.wb_valid     = MEM_valid;
      wb_next_s.wb_RegWrite  = MEM_RegWrite;
      wb_next_s.wb_MemToReg  = MEM_MemToReg;
      wb_next_s.wb_Rd        = MEM_Rd;
      wb_next_s.wb_ALUResult = MEM_ALUResult;
      wb_next_s.wb_ReadData  = MEM_ReadData;
    end
  end

  // MEM/WB register: D flip-flop with enable
  always_ff @(posedge clk) begin
    if (wb_en_s) begin
      wb_r <= wb_next_s;
    end else begin
      wb_r <= wb_r;
    end
  end

  // Retire counter: an instruction leaves WB on any unstalled edge
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_r <= '0;
    end else if (wb_r.wb_valid && !stall) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  mux_64x2to1 #(.W(DATA_W)) u_wb_mux (
    .a   (wb_r.wb_ALUResult),
    .b   (wb_r.wb_ReadData),
    .sel (wb_r.wb_MemToReg),
    .y   (WriteData)
  );

  // XZR is hardwired to zero, so writes to it never reach the register file.
  assign reg_write_s    = wb_r.wb_valid & wb_r.wb_RegWrite & (wb_r.wb_Rd != XZR);
  assign RegWrite_toReg = reg_write_s;
  assign WriteReg       = wb_r.wb_Rd;
  assign bypassA        = reg_write_s & (wb_r.wb_Rd == ID_Rn);
  assign bypassB        = reg_write_s & (wb_r.wb_Rd == ID_Ab);
  assign retired        = retired_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the MEM/WB slot and retire count.
module tb_writeback_stage;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              MEM_valid, MEM_RegWrite, MEM_MemToReg;
  logic [4:0]        MEM_Rd;
  logic [DATA_W-1:0] MEM_ALUResult, MEM_ReadData;
  logic              stall, flush;
  logic [4:0]        ID_Rn, ID_Ab;
  logic              RegWrite_toReg;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              bypassA, bypassB;
  logic [CNT_W-1:0]  retired;

  int tests = 0;
  int fails = 0;

  // Model: the instruction occupying WB (or none) and the retire count
  logic        m_valid, m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [63:0] m_alu, m_rdat;
  logic [31:0] m_cnt;

  writeback_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .MEM_valid      (MEM_valid),
    .MEM_RegWrite   (MEM_RegWrite),
    .MEM_MemToReg   (MEM_MemToReg),
    .MEM_Rd         (MEM_Rd),
    .MEM_ALUResult  (MEM_ALUResult),
    .MEM_ReadData   (MEM_ReadData),
    .stall          (stall),
    .flush          (flush),
    .ID_Rn          (ID_Rn),
    .ID_Ab          (ID_Ab),
    .RegWrite_toReg (RegWrite_toReg),
    .WriteReg       (WriteReg),
    .WriteData      (WriteData),
    .bypassA        (bypassA),
    .bypassB        (bypassB),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic exp_we;
    exp_we = m_valid && m_rw && (m_rd != 5'd31);
    chk("m_regwrite", {63'd0, RegWrite_toReg}, {63'd0, exp_we});
    chk("m_writereg", {59'd0, WriteReg}, {59'd0, m_rd});
    chk("m_writedata", WriteData, m_m2r ? m_rdat : m_alu);
    chk("m_bypassA", {63'd0, bypassA}, {63'd0, exp_we && (m_rd == ID_Rn)});
    chk("m_bypassB", {63'd0, bypassB}, {63'd0, exp_we && (m_rd == ID_Ab)});
    chk("m_retired", {32'd0, retired}, {32'd0, m_cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      {m_valid, m_rw, m_m2r, m_rd, m_alu, m_rdat} = '0;
      m_cnt = 32'd0;
    end else begin
      if (m_valid && !stall) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        {m_valid, m_rw, m_m2r, m_rd, m_alu, m_rdat} = '0;
      end else if (!stall) begin
        m_valid = MEM_valid; m_rw = MEM_RegWrite; m_m2r = MEM_MemToReg;
        m_rd = MEM_Rd; m_alu = MEM_ALUResult; m_rdat = MEM_ReadData;
      end
    end
    #1;
    chk_model();
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] rdat);
    MEM_valid = v; MEM_RegWrite = rw; MEM_MemToReg = m2r; MEM_Rd = rd;
    MEM_ALUResult = alu; MEM_ReadData = rdat;
  endtask

  initial begin
    {m_valid, m_rw, m_m2r, m_rd, m_alu, m_rdat} = '0;
    m_cnt = 32'd0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ID_Rn = 5'd0; ID_Ab = 5'd0;
    set_mem(1'b1, 1'b1, 1'b0, 5'd9, 64'hFFFF, 64'hAAAA);
    tick();
    tick();
    chk("rst_we", {63'd0, RegWrite_toReg}, 64'd0);
    chk("rst_wreg", {59'd0, WriteReg}, 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    chk("rst_retired", {32'd0, retired}, 64'd0);

    // ALU result writeback
    reset = 1'b0;
    set_mem(1'b1, 1'b1, 1'b0, 5'd3, 64'h1234, 64'h0);
    tick();
    chk("alu_we", {63'd0, RegWrite_toReg}, 64'd1);
    chk("alu_wreg", {59'd0, WriteReg}, 64'd3);
    chk("alu_wdata", WriteData, 64'h1234);

    // Load data writeback
    set_mem(1'b1, 1'b1, 1'b1, 5'd4, 64'h40, 64'hDEAD_BEEF);
    tick();
    chk("retired_first", {32'd0, retired}, 64'd1);
    chk("load_wdata", WriteData, 64'hDEAD_BEEF);

    // XZR destination is suppressed but still retires
    set_mem(1'b1, 1'b1, 1'b0, 5'd31, 64'h77, 64'h0);
    ID_Rn = 5'd31;
    tick();
    chk("xzr_we", {63'd0, RegWrite_toReg}, 64'd0);
    chk("xzr_bypassA", {63'd0, bypassA}, 64'd0);
    chk("xzr_retired", {32'd0, retired}, 64'd2);

    // Bypass detection
    set_mem(1'b1, 1'b1, 1'b0, 5'd5, 64'h55, 64'h0);
    ID_Rn = 5'd5; ID_Ab = 5'd7;
    tick();
    chk("byp_A", {63'd0, bypassA}, 64'd1);
    chk("byp_B_off", {63'd0, bypassB}, 64'd0);
    chk("xzr_counted", {32'd0, retired}, 64'd3);
    ID_Ab = 5'd5;
    #1;
    chk("byp_B_on", {63'd0, bypassB}, 64'd1);
    chk_model();

    // Stall holds outputs and count
    stall = 1'b1;
    set_mem(1'b1, 1'b1, 1'b0, 5'd9, 64'h99, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_wreg", {59'd0, WriteReg}, 64'd5);
      chk("stall_wdata", WriteData, 64'h55);
      chk("stall_retired", {32'd0, retired}, 64'd3);
    end
    stall = 1'b0;
    tick();
    chk("unstall_wreg", {59'd0, WriteReg}, 64'd9);
    chk("unstall_wdata", WriteData, 64'h99);
    chk("unstall_retired", {32'd0, retired}, 64'd4);

    // Flush with stall: bubble enters, nothing counted
    stall = 1'b1; flush = 1'b1;
    set_mem(1'b1, 1'b1, 1'b0, 5'd12, 64'hC0, 64'h0);
    tick();
    chk("flush_we", {63'd0, RegWrite_toReg}, 64'd0);
    chk("flush_retired", {32'd0, retired}, 64'd4);
    stall = 1'b0; flush = 1'b0;
    set_mem(1'b1, 1'b1, 1'b0, 5'd6, 64'h66, 64'h0);
    tick();
    chk("bubble_not_counted", {32'd0, retired}, 64'd4);
    chk("after_flush_we", {63'd0, RegWrite_toReg}, 64'd1);

    // Reset mid-stream under stall
    stall = 1'b1; reset = 1'b1;
    tick();
    chk("rst2_we", {63'd0, RegWrite_toReg}, 64'd0);
    chk("rst2_wreg", {59'd0, WriteReg}, 64'd0);
    chk("rst2_wdata", WriteData, 64'd0);
    chk("rst2_retired", {32'd0, retired}, 64'd0);
    reset = 1'b0; stall = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_mem(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
              5'($urandom_range(0, 31)), {$urandom, $urandom}, {$urandom, $urandom});
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      ID_Rn = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom_range(0, 31));
      ID_Ab = ($urandom_range(0, 1) == 0) ? MEM_Rd : 5'($urandom_range(0, 31));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
